// File: rtl/regfile_dmux.sv
// regfile_dmux: general-purpose register file with a one-hot write-select decoder.
//   - One write port (en/wsel/wdata), blocked while a bulk clear is running.
//   - Two combinational read ports with write-through bypass of the pending write.
//   - Bulk-clear engine: on clr, zeroes one register per cycle, R0 first.
// Build option: define REGFILE_ZERO_R0_EN to hardwire R0 to zero.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en, wsel, wdata     write request (ignored while busy)
//   rsel_a/b, rdata_a/b read selects and combinational read data
//   clr                 bulk-clear request, level-sampled in IDLE
//   busy                high while the clear engine runs (decoded from state)
//   wen_onehot          registered one-hot of the register written/cleared last edge
module regfile_dmux #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [SEL_W-1:0]      wsel,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [SEL_W-1:0]      rsel_a,
    input  logic [SEL_W-1:0]      rsel_b,
    output logic [WIDTH-1:0]      rdata_a,
    output logic [WIDTH-1:0]      rdata_b,
    input  logic                  clr,
    output logic                  busy,
    output logic [2**SEL_W-1:0]   wen_onehot
);

    localparam int unsigned NREGS = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NREGS - 1);
    localparam logic [NREGS-1:0] ONEHOT_0 = NREGS'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    cnt_q, cnt_d;
    logic [NREGS-1:0]    wen_onehot_q, wen_onehot_d;
    logic [WIDTH-1:0]    regs_q [NREGS];

    logic                we_c;
    logic [SEL_W-1:0]    widx_c;
    logic [WIDTH-1:0]    wval_c;
    logic                wsel_ok_c;
    logic                bypass_c;

    // Which write selects may actually land in the array.
`ifdef REGFILE_ZERO_R0_EN
    assign wsel_ok_c = (wsel != '0);
`else
    assign wsel_ok_c = 1'b1;
`endif

    // State, counter and observability register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wen_onehot_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wen_onehot_q <= wen_onehot_d;
        end
    end

    // Next-state logic and single shared write port into the array.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wen_onehot_d = '0;
        we_c         = 1'b0;
        widx_c       = wsel;
        wval_c       = wdata;
        case (state_q)
            IDLE: begin
                if (en && wsel_ok_c) begin
                    we_c         = 1'b1;
                    wen_onehot_d = ONEHOT_0 << wsel;
                end
                // A simultaneous write still lands; the clear zeroes it later.
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                we_c         = 1'b1;
                widx_c       = cnt_q;
                wval_c       = '0;
                wen_onehot_d = ONEHOT_0 << cnt_q;
                cnt_d        = cnt_q + SEL_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_c) begin
            regs_q[widx_c] <= wval_c;
        end
    end

    assign busy       = (state_q == CLEAR);
    assign wen_onehot = wen_onehot_q;

    // Bypass forwards only a write that will actually be committed this edge.
    assign bypass_c = !busy && en && wsel_ok_c;

    // Read ports.
    always_comb begin
        rdata_a = regs_q[rsel_a];
        rdata_b = regs_q[rsel_b];
        if (bypass_c && (rsel_a == wsel)) begin
            rdata_a = wdata;
        end
        if (bypass_c && (rsel_b == wsel)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: tb/tb_regfile_dmux.sv
// Self-checking bench for regfile_dmux: directed test-plan scenarios followed by
// random traffic, all compared against a behavioural model of the register file.
module tb_regfile_dmux;

    localparam int NREGS = 16;
`ifdef REGFILE_ZERO_R0_EN
    localparam bit ZR0 = 1'b1;
`else
    localparam bit ZR0 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  wsel;
    logic [15:0] wdata;
    logic [3:0]  rsel_a;
    logic [3:0]  rsel_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic        clr;
    logic        busy;
    logic [15:0] wen_onehot;

    int n_cmp = 0;
    int n_err = 0;

    regfile_dmux #(.WIDTH(16), .SEL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wsel       (wsel),
        .wdata      (wdata),
        .rsel_a     (rsel_a),
        .rsel_b     (rsel_b),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .clr        (clr),
        .busy       (busy),
        .wen_onehot (wen_onehot)
    );

    always #5 clk = ~clk;

    // Behavioural model: array contents, number of registers still to clear,
    // and the index touched on the last edge (-1 when nothing was touched).
    logic [15:0] m_regs [NREGS];
    int          m_left;
    int          m_wen_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] <= 16'h0;
            m_left    <= 0;
            m_wen_idx <= -1;
        end else if (m_left > 0) begin
            m_regs[NREGS - m_left] <= 16'h0;
            m_wen_idx              <= NREGS - m_left;
            m_left                 <= m_left - 1;
        end else begin
            if (en && !(ZR0 && wsel == 4'd0)) begin
                m_regs[wsel] <= wdata;
                m_wen_idx    <= int'(wsel);
            end else begin
                m_wen_idx <= -1;
            end
            if (clr) m_left <= NREGS;
        end
    end

    function automatic logic [15:0] exp_read(input logic [3:0] sel);
        if (ZR0 && sel == 4'd0) return 16'h0;
        if (m_left == 0 && en && sel == wsel && !(ZR0 && wsel == 4'd0)) return wdata;
        return m_regs[sel];
    endfunction

    function automatic logic [15:0] exp_wen();
        if (m_wen_idx < 0) return 16'h0;
        return 16'(32'd1 << m_wen_idx);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then compare against the model.
    task automatic apply(input logic e, input logic [3:0] ws, input logic [15:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb, input logic c);
        @(negedge clk);
        en = e; wsel = ws; wdata = wd; rsel_a = ra; rsel_b = rb; clr = c;
        #1;
        check("rdata_a", 32'(rdata_a), 32'(exp_read(ra)));
        check("rdata_b", 32'(rdata_b), 32'(exp_read(rb)));
        check("busy", 32'(busy), 32'(m_left > 0));
        check("wen_onehot", 32'(wen_onehot), 32'(exp_wen()));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wsel = '0; wdata = '0;
        rsel_a = '0; rsel_b = '0; clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        apply(0, 0, 16'h0, 3, 15, 0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wen", 32'(wen_onehot), 32'd0);
        check("rst_rd", 32'(rdata_a), 32'd0);

        // Write and read back.
        apply(1, 3, 16'hA5A5, 0, 0, 0);
        apply(1, 15, 16'h1234, 0, 0, 0);
        check("wr_wen_r3", 32'(wen_onehot), 32'h0008);
        apply(0, 0, 16'h0, 3, 15, 0);
        check("wr_wen_r15", 32'(wen_onehot), 32'h8000);
        check("wr_r3", 32'(rdata_a), 32'hA5A5);
        check("wr_r15", 32'(rdata_b), 32'h1234);

        // Enable off.
        apply(0, 7, 16'hFFFF, 7, 7, 0);
        apply(0, 0, 16'h0, 7, 7, 0);
        check("en_off_r7", 32'(rdata_a), 32'd0);
        check("en_off_wen", 32'(wen_onehot), 32'd0);

        // Bypass.
        apply(1, 5, 16'hBEEF, 5, 3, 0);
        check("bypass_pre", 32'(rdata_a), 32'hBEEF);
        apply(0, 0, 16'h0, 5, 5, 0);
        check("bypass_post", 32'(rdata_a), 32'hBEEF);

        // Bulk clear: fill, pulse clr, walk the one-hot.
        for (int i = 0; i < NREGS; i++) apply(1, 4'(i), 16'(i + 1), 4'(i), 0, 0);
        apply(0, 0, 16'h0, 9, 10, 1);
        for (int k = 0; k < NREGS; k++) begin
            if (k == 8) apply(1, 4, 16'hFFFF, 4, 12, 0);
            else        apply(0, 0, 16'h0, 4'(k), 15, 0);
            check("clr_busy", 32'(busy), 32'd1);
            check("clr_walk", 32'(wen_onehot), (k == 0) ? 32'd0 : (32'd1 << (k - 1)));
            if (k == 8) check("clr_midwrite", 32'(rdata_a), 32'd0);
        end
        apply(1, 2, 16'h55AA, 9, 9, 0);
        check("clr_done_busy", 32'(busy), 32'd0);
        check("clr_last_wen", 32'(wen_onehot), 32'h8000);
        for (int i = 0; i < NREGS; i += 2) begin
            apply(0, 0, 16'h0, 4'(i), 4'(i + 1), 0);
            check("clr_zero_a", 32'(rdata_a), (i == 2) ? 32'h55AA : 32'd0);
            check("clr_zero_b", 32'(rdata_b), 32'd0);
        end

        // Reset mid-clear.
        for (int i = 1; i < NREGS; i++) apply(1, 4'(i), 16'(16'h100 + i), 0, 0, 0);
        apply(0, 0, 16'h0, 0, 0, 1);
        repeat (6) apply(0, 0, 16'h0, 14, 15, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_wen", 32'(wen_onehot), 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            rsel_a = 4'(i);
            #1;
            check("rstmid_rd", 32'(rdata_a), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // R0 write.
        apply(1, 0, 16'h7777, 0, 1, 0);
        check("r0_same", 32'(rdata_a), ZR0 ? 32'd0 : 32'h7777);
        apply(0, 0, 16'h0, 0, 0, 0);
        check("r0_after", 32'(rdata_a), ZR0 ? 32'd0 : 32'h7777);
        check("r0_wen", 32'(wen_onehot), ZR0 ? 32'd0 : 32'd1);

        // Random traffic, including clr held across a clear end.
        for (int n = 0; n < 800; n++) begin
            logic [3:0] ws;
            logic [3:0] ra;
            ws = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? ws : 4'($urandom_range(0, 15));
            apply(1'($urandom_range(0, 1)), ws, 16'($urandom),
                  ra, 4'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0));
        end
        apply(0, 0, 16'h0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
